hybrid_pwm_sd_multi: RTL and testbench

- Parametrised N-channel hybrid PWM / sigma-delta audio DAC: a PWM of width PWM_BITS wrapped in a first-order sigma-delta with a D_WIDTH-bit fractional accumulator per channel.
- Next generation of the stereo hybrid DAC; sits between the audio mixer and the board's 1-bit audio pins.
- Adds channel-count, width and PWM-resolution parameters, a synchronous reset, saturating anti-pop ramps, an optional dump, and status outputs.
- One shared multiplier is time-multiplexed across channels.

---
 rtl/hybrid_pwm_sd_pkg.sv | 35 +++
 rtl/hybrid_pwm_sd_multi_antipop.sv | 52 +++++
 rtl/hybrid_pwm_sd_multi.sv | 109 ++++++++++
 tb/tb_hybrid_pwm_sd_multi.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hybrid_pwm_sd_pkg.sv
// Shared widths, constants and parameter legality helpers for the hybrid
// PWM / sigma-delta DAC.
package hybrid_pwm_sd_pkg;

    // Threshold register width: one PWM count wide.
    function automatic int thr_width(input int pwm_bits);
        return pwm_bits;
    endfunction

    // Accumulator width: sample * (2^PWM_BITS-2) plus offsets fits in D+P bits.
    function automatic int acc_width(input int d_width, input int pwm_bits);
        return d_width + pwm_bits;
    endfunction

    // Half-LSB centring offset added on every accumulation.
    function automatic logic [63:0] centre_offset(input int d_width);
        return 64'(1) << (d_width - 1);
    endfunction

    // Fraction value restored by an accumulator dump.
    function automatic logic [63:0] dump_fraction(input int d_width);
        return 64'(1) << (d_width - 1);
    endfunction

    // Parameter legality, evaluated at elaboration by the top level.
    function automatic bit params_legal(input int channels, input int d_width,
                                        input int pwm_bits, input int ramp_bits,
                                        input int dump_bits);
        return (channels >= 1) && (pwm_bits >= 2) && (pwm_bits < 31) &&
               (channels <= (1 << pwm_bits) - 1) &&
               (ramp_bits >= 2) && (ramp_bits <= d_width) &&
               (d_width + pwm_bits <= 64) && (dump_bits >= 1);
    endfunction

endpackage

// File: rtl/hybrid_pwm_sd_multi_antipop.sv
// Anti-pop ramp: power-on ramp down from full scale to mid-scale, and a
// sticky terminate ramp back up to full scale. Steps once per dump pulse.
module pwm_sd_antipop #(
    parameter int RAMP_BITS = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 terminate,
    input  logic                 step,
    output logic [RAMP_BITS-1:0] ramp_val,
    output logic                 init_done,
    output logic                 ramping
);
    localparam logic [RAMP_BITS-1:0] RAMP_HALF = RAMP_BITS'(1) << (RAMP_BITS - 1);
    localparam logic [RAMP_BITS-1:0] RAMP_FULL = '1;

    logic [RAMP_BITS-1:0] ramp_cnt;
    logic                 term_latch;

    // Ramp counter, in-use ramp value (one step behind the counter) and status.
    always_ff @(posedge clk) begin
        if (reset) begin
            ramp_cnt   <= RAMP_FULL;
            ramp_val   <= RAMP_FULL;
            init_done  <= 1'b0;
            ramping    <= 1'b1;
            term_latch <= 1'b0;
        end else if (terminate && init_done && !term_latch) begin
            term_latch <= 1'b1;
            ramping    <= 1'b1;
            ramp_cnt   <= RAMP_HALF;
            ramp_val   <= RAMP_HALF;
        end else begin
            if (step) begin
                if (term_latch) begin
                    ramp_val <= ramp_cnt;
                    if (ramp_cnt != RAMP_FULL)
                        ramp_cnt <= ramp_cnt + RAMP_BITS'(1);
                end else if (!init_done) begin
                    ramp_val <= ramp_cnt;
                    if (ramp_cnt != RAMP_HALF)
                        ramp_cnt <= ramp_cnt - RAMP_BITS'(1);
                end
            end
            if (!init_done && !term_latch && ramp_cnt == RAMP_HALF) begin
                init_done <= 1'b1;
                ramping   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hybrid_pwm_sd_multi.sv
// N-channel hybrid PWM / first-order sigma-delta DAC with one shared,
// time-multiplexed multiplier. Thresholds computed during a frame are
// committed together at the next frame start.
module hybrid_pwm_sd_multi
    import hybrid_pwm_sd_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int D_WIDTH     = 16,
    parameter int PWM_BITS    = 5,
    parameter int RAMP_BITS   = 14,
    parameter int DUMP_BITS   = 8,
    parameter int DUMP_ENABLE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        terminate,
    input  logic [CHANNELS*D_WIDTH-1:0] d,
    output logic [CHANNELS-1:0]         q,
    output logic                        init_done,
    output logic                        ramping
);
    localparam int TW = thr_width(PWM_BITS);
    localparam int AW = acc_width(D_WIDTH, PWM_BITS);
    localparam logic [AW-1:0]       CENTRE    = AW'(centre_offset(D_WIDTH));
    localparam logic [D_WIDTH-1:0]  DUMP_FRAC = D_WIDTH'(dump_fraction(D_WIDTH));
    localparam logic [PWM_BITS-1:0] GAIN      = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] CH_LAST   = PWM_BITS'(CHANNELS);

    if (!params_legal(CHANNELS, D_WIDTH, PWM_BITS, RAMP_BITS, DUMP_BITS)) begin : g_bad_params
        $error("hybrid_pwm_sd_multi: illegal parameter combination");
    end

    logic [PWM_BITS-1:0]  cnt;
    logic [DUMP_BITS-1:0] frame_cnt;
    logic [TW-1:0]        thr      [CHANNELS];
    logic [TW-1:0]        thr_next [CHANNELS];
    logic [D_WIDTH-1:0]   frac     [CHANNELS];
    logic [RAMP_BITS-1:0] ramp_val;
    logic                 frame_start, step, dump, busy;
    logic [PWM_BITS-1:0]  chan;
    logic [D_WIDTH-1:0]   s_sel, frac_sel;
    logic [AW-1:0]        acc;

    assign frame_start = (cnt == '0);
    assign step        = frame_start && (frame_cnt == '0);
    assign dump        = step && (DUMP_ENABLE != 0);
    assign busy        = (cnt != '0) && (cnt <= CH_LAST);
    assign chan        = cnt - PWM_BITS'(1);

    pwm_sd_antipop #(.RAMP_BITS(RAMP_BITS)) u_antipop (
        .clk       (clk),
        .reset     (reset),
        .terminate (terminate),
        .step      (step),
        .ramp_val  (ramp_val),
        .init_done (init_done),
        .ramping   (ramping)
    );

    // Shared multiply-accumulate for the channel selected by the PWM count.
    always_comb begin
        s_sel    = '0;
        frac_sel = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (chan == PWM_BITS'(k)) begin
                s_sel    = d[k*D_WIDTH +: D_WIDTH];
                frac_sel = frac[k];
            end
        end
        if (ramping)
            s_sel = D_WIDTH'(ramp_val) << (D_WIDTH - RAMP_BITS);
        acc = AW'(s_sel) * AW'(GAIN) + CENTRE + AW'(frac_sel);
    end

    // PWM counter, comparators, frame sequencing and per-channel state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            frame_cnt <= '0;
            q         <= '0;
            for (int k = 0; k < CHANNELS; k++) begin
                thr[k]      <= '0;
                thr_next[k] <= '0;
                frac[k]     <= DUMP_FRAC;
            end
        end else begin
            cnt <= cnt + PWM_BITS'(1);
            for (int k = 0; k < CHANNELS; k++)
                q[k] <= (cnt < thr[k]);
            if (frame_start) begin
                frame_cnt <= frame_cnt + DUMP_BITS'(1);
                for (int k = 0; k < CHANNELS; k++) begin
                    thr[k] <= thr_next[k];
                    if (dump)
                        frac[k] <= DUMP_FRAC;
                end
            end
            if (busy) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (chan == PWM_BITS'(k)) begin
                        thr_next[k] <= acc[AW-1:D_WIDTH];
                        frac[k]     <= acc[D_WIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hybrid_pwm_sd_multi.sv
// Directed bench: a 2-channel and a 4-channel instance share clock and reset.
// Each frame the number of high q clocks per channel equals that frame's
// threshold; expected thresholds are hand-computed from the arithmetic.
module tb_hybrid_pwm_sd_multi;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        term_a = 1'b0;
    logic        term_b = 1'b0;
    logic [31:0] d_a;
    logic [63:0] d_b;
    logic [1:0]  q_a;
    logic [3:0]  q_b;
    logic        init_a, ramp_a, init_b, ramp_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ca[2];
    int cb[4];

    hybrid_pwm_sd_multi #(.CHANNELS(2), .D_WIDTH(16), .PWM_BITS(5), .RAMP_BITS(4),
                          .DUMP_BITS(2), .DUMP_ENABLE(1)) dut_a (
        .clk(clk), .reset(reset), .terminate(term_a), .d(d_a),
        .q(q_a), .init_done(init_a), .ramping(ramp_a));

    hybrid_pwm_sd_multi #(.CHANNELS(4), .D_WIDTH(16), .PWM_BITS(5), .RAMP_BITS(4),
                          .DUMP_BITS(2), .DUMP_ENABLE(1)) dut_b (
        .clk(clk), .reset(reset), .terminate(term_b), .d(d_b),
        .q(q_b), .init_done(init_b), .ramping(ramp_b));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Counts high q clocks over the 32 edges following a frame-start edge.
    task automatic measure_frame(input bit pulse);
        for (int k = 0; k < 2; k++) ca[k] = 0;
        for (int k = 0; k < 4; k++) cb[k] = 0;
        term_a = pulse;
        for (int i = 0; i < 32; i++) begin
            @(posedge clk);
            #1;
            term_a = 1'b0;
            for (int k = 0; k < 2; k++) ca[k] += int'(q_a[k]);
            for (int k = 0; k < 4; k++) cb[k] += int'(q_b[k]);
        end
    endtask

    // Power-on ramp, entered with reset asserted; covers frames 0..24.
    task automatic power_on(input int pulse_frame, input string run);
        int ramp_blk[6];
        int first4[4];
        int blk[6];
        ramp_blk = '{115, 107, 100, 92, 85, 77};
        first4   = '{29, 28, 29, 29};
        for (int j = 0; j < 6; j++) blk[j] = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        for (int f = 0; f <= 24; f++) begin
            measure_frame(f == pulse_frame);
            if (f == 0) begin
                check_val($sformatf("%s_frame0_ch0", run), ca[0], 0);
                check_val($sformatf("%s_frame0_ch1", run), ca[1], 0);
            end
            if (f >= 1 && f <= 4)
                check_val($sformatf("%s_ramp15_f%0d", run, f), ca[0], first4[f-1]);
            if (f >= 1) blk[(f-1)/4] += ca[0];
            if (f == 4)
                check_val($sformatf("%s_ramp15_ch1_sum", run), ca[1], 29);
            if (f == 23) begin
                check_val($sformatf("%s_init_before", run), int'(init_a), 0);
                check_val($sformatf("%s_ramping_before", run), int'(ramp_a), 1);
            end
        end
        check_val($sformatf("%s_init_after", run), int'(init_a), 1);
        check_val($sformatf("%s_ramping_after", run), int'(ramp_a), 0);
        check_val($sformatf("%s_init_b", run), int'(init_b), 1);
        for (int j = 0; j < 6; j++)
            check_val($sformatf("%s_ramp_block%0d", run, j), blk[j], ramp_blk[j]);
    endtask

    initial begin
        int exp_mid[8];
        int exp_hi[8];
        int exp_lo[8];
        int b0[4];
        int b3[4];
        int term_exp[10];
        int tblk[10];
        exp_mid  = '{16, 15, 16, 15, 16, 15, 16, 15};
        exp_hi   = '{30, 30, 31, 30, 31, 30, 31, 30};
        exp_lo   = '{0, 1, 0, 1, 0, 1, 0, 1};
        b0       = '{1, 0, 1, 0};
        b3       = '{30, 31, 30, 31};
        term_exp = '{62, 70, 77, 85, 92, 100, 107, 115, 115, 115};
        for (int j = 0; j < 10; j++) tblk[j] = 0;

        d_a = {16'h8000, 16'h8000};
        d_b = {16'hFFFF, 16'hC000, 16'h4000, 16'h0000};
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_q_a", int'(q_a), 0);
        check_val("reset_q_b", int'(q_b), 0);
        check_val("reset_init", int'(init_a), 0);
        check_val("reset_ramping", int'(ramp_a), 1);

        power_on(10, "por1");

        for (int f = 25; f <= 36; f++) begin
            measure_frame(1'b0);
            if (f >= 29) begin
                check_val($sformatf("mid_ch0_f%0d", f), ca[0], exp_mid[f-29]);
                check_val($sformatf("mid_ch1_f%0d", f), ca[1], exp_mid[f-29]);
            end
            if (f >= 29 && f <= 32) begin
                check_val($sformatf("b_ch0_f%0d", f), cb[0], b0[f-29]);
                check_val($sformatf("b_ch1_f%0d", f), cb[1], 8);
                check_val($sformatf("b_ch2_f%0d", f), cb[2], 23);
                check_val($sformatf("b_ch3_f%0d", f), cb[3], b3[f-29]);
            end
        end

        d_a = {16'h0000, 16'hFFFF};
        for (int f = 37; f <= 45; f++) begin
            measure_frame(1'b0);
            if (f >= 38) begin
                check_val($sformatf("full_ch0_f%0d", f), ca[0], exp_hi[f-38]);
                check_val($sformatf("zero_ch1_f%0d", f), ca[1], exp_lo[f-38]);
            end
        end

        measure_frame(1'b1);
        check_val("term_ramping", int'(ramp_a), 1);
        for (int f = 47; f <= 88; f++) begin
            measure_frame(1'b0);
            if (f >= 49) tblk[(f-49)/4] += ca[0];
            if (f == 88)
                check_val("term_hold_ch1_f88", ca[1], 29);
        end
        for (int j = 0; j < 10; j++)
            check_val($sformatf("term_block%0d", j), tblk[j], term_exp[j]);

        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_val("midreset_q_a", int'(q_a), 0);
        check_val("midreset_q_b", int'(q_b), 0);
        check_val("midreset_init", int'(init_a), 0);
        check_val("midreset_ramping", int'(ramp_a), 1);

        power_on(-1, "por2");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
